// File: rtl/sm_hex_scan_pkg.sv
// Shared constants and helpers for the multiplexed hex display driver.
package sm_hex_scan_pkg;

  // Segment bit positions on the shared segment bus.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments unlit, for active-low and active-high segment wiring.
  localparam logic [6:0] SEG_OFF_AL = 7'h7F;
  localparam logic [6:0] SEG_OFF_AH = 7'h00;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_hex_display.sv
// Combinational hex nibble to seven-segment decoder; active-low output,
// bit0 = a ... bit6 = g.
module sm_hex_display
  import sm_hex_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Standard 0..F glyphs, a 0 bit lights the segment.
  always_comb begin
    // NOTE: every path assigns seg (default first), so no latch is inferred.
    seg = SEG_OFF_AL;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF_AL;
    endcase
  end

endmodule

// File: rtl/sm_hex_scan.sv
// Time-multiplexed hex display driver: scans DIGITS digits over one segment
// bus, with tear-free frame-synchronous update, leading-zero blanking,
// per-digit decimal points and an anode blank interval against ghosting.
module sm_hex_scan
  import sm_hex_scan_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int IW = idx_w(DIGITS);
  localparam int PW = idx_w(SCAN_DIV);

  localparam logic [PW-1:0]     P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     I_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                boundary;

  // Staging holds the last load until the frame boundary; shadow is what
  // the scan actually displays, so a frame never mixes old and new digits.
  logic [4*DIGITS-1:0] stg_val;
  logic [DIGITS-1:0]   stg_dp;
  logic                stg_lz;
  logic [4*DIGITS-1:0] shd_val;
  logic [DIGITS-1:0]   shd_dp;
  logic                shd_lz;

  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   an_hot;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_blank;
  logic [6:0]          dec_seg;

  assign tick     = (prescaler == P_LAST);
  assign boundary = tick && (idx == I_LAST);

  // Slot prescaler and digit index; the index wrap marks the frame boundary.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Load staging, frame-synchronous shadow transfer and frame_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_val     <= '0;
      stg_dp      <= '0;
      stg_lz      <= 1'b0;
      shd_val     <= '0;
      shd_dp      <= '0;
      shd_lz      <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (load) begin
        stg_val <= value_in;
        stg_dp  <= dp_in;
        stg_lz  <= lz_blank;
      end
      if (boundary) begin
        // A load coinciding with the boundary bypasses staging entirely.
        pending <= 1'b0;
        if (load) begin
          shd_val <= value_in;
          shd_dp  <= dp_in;
          shd_lz  <= lz_blank;
        end else if (pending) begin
          shd_val <= stg_val;
          shd_dp  <= stg_dp;
          shd_lz  <= stg_lz;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i > 0 blanks when it and every higher nibble are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (shd_val[4*i +: 4] == 4'h0);
      blank_mask[i] = shd_lz && zero_above;
    end
  end

  // Select the nibble, decimal point, blank flag and anode of the current digit.
  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nib   = shd_val[4*i +: 4];
        sel_dp    = shd_dp[i];
        sel_blank = blank_mask[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  sm_hex_display u_dec (
    .hex (sel_nib),
    .seg (dec_seg)
  );

  // Registered pin drivers, one cycle behind the prescaler/index state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else begin
      if (sel_blank)
        seg <= SEG_OFF;
      else
        seg <= (SEG_ACTIVE_LOW != 0) ? dec_seg : ~dec_seg;
      dp <= (SEG_ACTIVE_LOW != 0) ? ~sel_dp : sel_dp;
      if (prescaler >= P_BLANK)
        an <= (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
      else
        an <= AN_OFF;
    end
  end

endmodule

// File: tb/tb_sm_hex_scan.sv
// Self-checking bench for sm_hex_scan (4 digits, 4-cycle slots, 1 blank
// cycle, active-low pins) against a frame-level behavioural model.
module tb_sm_hex_scan;

  localparam int D     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = D * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: display content and the time since reset release.
  int          cyc = 0;
  logic [15:0] m_stg_val = '0, m_shd_val = '0;
  logic [3:0]  m_stg_dp = '0, m_shd_dp = '0;
  logic        m_stg_lz = 1'b0, m_shd_lz = 1'b0, m_pend = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;
  logic        saw_a;

  sm_hex_scan #(
    .DIGITS(D), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an), .pending(pending),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Active-low glyph built from the list of lit segment letters.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] r;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";     4'h2: s = "abdeg";  4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";  4'h6: s = "acdefg"; 4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg"; 4'hA: s = "abcefg"; 4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";  4'hE: s = "adefg";  default: s = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: update the model for this edge, then compare all outputs.
  task automatic step();
    int         p, ix;
    logic       bnd, blanked;
    logic [3:0] nib;
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      m_stg_val = '0; m_stg_dp = '0; m_stg_lz = 1'b0;
      m_shd_val = '0; m_shd_dp = '0; m_shd_lz = 1'b0; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      p       = cyc % DIV;
      ix      = (cyc / DIV) % D;
      bnd     = ((cyc % FRAME) == FRAME - 1);
      nib     = 4'(m_shd_val >> (4 * ix));
      blanked = m_shd_lz && (ix > 0) && ((m_shd_val >> (4 * ix)) == 16'h0);
      e_an    = (p >= BLANK) ? ~(4'b0001 << ix) : 4'hF;
      e_seg   = blanked ? 7'h7F : glyph(nib);
      e_dp    = ~m_shd_dp[ix];
      e_fs    = bnd;
      if (bnd) begin
        if (load) begin
          m_shd_val = value_in; m_shd_dp = dp_in; m_shd_lz = lz_blank;
        end else if (m_pend) begin
          m_shd_val = m_stg_val; m_shd_dp = m_stg_dp; m_shd_lz = m_stg_lz;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_stg_val = value_in; m_stg_dp = dp_in; m_stg_lz = lz_blank;
        m_pend = 1'b1;
      end
      cyc++;
    end
    #1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("pending", 16'(pending), 16'(m_pend));
    check("frame_start", 16'(frame_start), 16'(e_fs));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the next edge to be applied sits at the given frame phase.
  task automatic advance_to(input int phase);
    for (int k = 0; k < FRAME; k++) begin
      if ((cyc % FRAME) == phase) break;
      step();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value_in = v; dp_in = d; lz_blank = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Free-running scan of the all-zero display, frame pulses every 16 cycles.
    run(2 * FRAME + 3);

    // Mid-frame load of 1234, then a full frame of scan order.
    advance_to(5);
    do_load(16'h1234, 4'h0, 1'b0);
    run(FRAME + FRAME);

    // Tear-free update: AAAA then 5555 two cycles later, same frame.
    advance_to(3);
    saw_a = 1'b0;
    do_load(16'hAAAA, 4'h0, 1'b0);
    if (seg === glyph(4'hA)) saw_a = 1'b1;
    step();
    if (seg === glyph(4'hA)) saw_a = 1'b1;
    do_load(16'h5555, 4'h0, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (seg === glyph(4'hA)) saw_a = 1'b1;
    end
    check("no_A_shown", 16'(saw_a), 16'h0);
    check("seg_after_5555", 16'(seg), 16'(glyph(4'h5)));

    // Load on the boundary tick itself.
    advance_to(FRAME - 1);
    do_load(16'hBEEF, 4'h0, 1'b0);
    run(FRAME + 2);

    // Leading-zero blanking with a decimal point on a blanked digit.
    advance_to(7);
    do_load(16'h0040, 4'b1000, 1'b1);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 1'b1);
    run(2 * FRAME);

    // Reset while a load is pending discards it.
    advance_to(4);
    do_load(16'h9999, 4'hF, 1'b0);
    run(2);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(FRAME + 4);

    // Randomized loads at arbitrary phases.
    for (int k = 0; k < 400; k++) begin
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
      lz_blank = 1'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) value_in = value_in & 16'h00FF;
      step();
    end
    load = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
